// File: rtl/ppg_search_ctrl.sv
// ppg_search_ctrl
//   Closed-loop front-end controller for the finger-clip PPG channel.
//   Calibrates the RED and then the IR LED, one after the other. For each LED
//   it binary-searches the 7-bit DC compensation code against TARGET, then
//   binary-searches the 4-bit PGA gain. A gain trial is rejected if the
//   measured swing clips or exceeds SWING_MAX. After calibration it runs
//   continuously and emits alternating, LED-tagged samples.
//
// Ports
//   clk, reset       system clock, synchronous active-high reset
//   start            one-cycle pulse that starts or restarts calibration
//                    (ignored while busy)
//   vppg[7:0]        digitised PPG sample (unsigned)
//   led_red, led_ir  LED enables (never both high)
//   dc_comp[6:0]     DC compensation DAC code currently applied
//   pga_gain[3:0]    PGA gain code currently applied
//   busy             high while calibrating
//   cal_done         high from calibration end until next start/reset
//   dc_red, dc_ir    calibrated DC codes
//   gain_red/ir      calibrated gain codes
//   sample_valid     one-cycle strobe in the run loop
//   sample[7:0]      vppg captured with the strobe
//   sample_is_ir     0 = RED sample, 1 = IR sample
module ppg_search_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MEAS_CYCLES   = 64,
  parameter int unsigned TARGET        = 128,
  parameter int unsigned SWING_MAX     = 192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] vppg,
  output logic       led_red,
  output logic       led_ir,
  output logic [6:0] dc_comp,
  output logic [3:0] pga_gain,
  output logic       busy,
  output logic       cal_done,
  output logic [6:0] dc_red,
  output logic [6:0] dc_ir,
  output logic [3:0] gain_red,
  output logic [3:0] gain_ir,
  output logic       sample_valid,
  output logic [7:0] sample,
  output logic       sample_is_ir
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + MEAS_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] MEAS_LD   = CNT_W'(MEAS_CYCLES);
  localparam logic [CNT_W-1:0] TOTAL_LD  = CNT_W'(SETTLE_CYCLES + MEAS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]       TARGET_V  = 8'(TARGET);
  localparam logic [8:0]       SWING_V   = 9'(SWING_MAX);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DC_TRY,
    S_DC_SETTLE,
    S_DC_EVAL,
    S_G_TRY,
    S_G_MEAS,
    S_G_EVAL,
    S_NEXT_LED,
    S_RUN_GAP,
    S_RUN_SETTLE,
    S_RUN_SAMPLE
  } state_e;

  state_e           state_q, state_d;
  logic             led_sel_q, led_sel_d;   // 0 = RED, 1 = IR
  logic             led_red_q, led_red_d;
  logic             led_ir_q, led_ir_d;
  logic [6:0]       dc_q, dc_d;
  logic [3:0]       gain_q, gain_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       vreg_q, vreg_d;
  logic [7:0]       min_q, min_d;
  logic [7:0]       max_q, max_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [6:0]       dc_red_q, dc_red_d;
  logic [6:0]       dc_ir_q, dc_ir_d;
  logic [3:0]       gain_red_q, gain_red_d;
  logic [3:0]       gain_ir_q, gain_ir_d;
  logic             svalid_q, svalid_d;
  logic [7:0]       sample_q, sample_d;
  logic             sis_ir_q, sis_ir_d;

  logic [8:0]       swing;
  logic             clip;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      led_sel_q  <= 1'b0;
      led_red_q  <= 1'b0;
      led_ir_q   <= 1'b0;
      dc_q       <= '0;
      gain_q     <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      vreg_q     <= '0;
      min_q      <= '0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dc_red_q   <= '0;
      dc_ir_q    <= '0;
      gain_red_q <= '0;
      gain_ir_q  <= '0;
      svalid_q   <= 1'b0;
      sample_q   <= '0;
      sis_ir_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      led_sel_q  <= led_sel_d;
      led_red_q  <= led_red_d;
      led_ir_q   <= led_ir_d;
      dc_q       <= dc_d;
      gain_q     <= gain_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      vreg_q     <= vreg_d;
      min_q      <= min_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dc_red_q   <= dc_red_d;
      dc_ir_q    <= dc_ir_d;
      gain_red_q <= gain_red_d;
      gain_ir_q  <= gain_ir_d;
      svalid_q   <= svalid_d;
      sample_q   <= sample_d;
      sis_ir_q   <= sis_ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    led_sel_d  = led_sel_q;
    led_red_d  = led_red_q;
    led_ir_d   = led_ir_q;
    dc_d       = dc_q;
    gain_d     = gain_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    vreg_d     = vreg_q;
    min_d      = min_q;
    max_d      = max_q;
    busy_d     = busy_q;
    done_d     = done_q;
    dc_red_d   = dc_red_q;
    dc_ir_d    = dc_ir_q;
    gain_red_d = gain_red_q;
    gain_ir_d  = gain_ir_q;
    svalid_d   = 1'b0;
    sample_d   = sample_q;
    sis_ir_d   = sis_ir_q;

    // Swing is evaluated at 9 bits so max < min would wrap large and clip.
    swing = {1'b0, max_q} - {1'b0, min_q};
    clip  = (max_q == 8'hFF) || (min_q == 8'h00) || (swing > SWING_V);

    case (state_q)
      S_IDLE: ;

      S_DC_TRY: begin
        dc_d[bit_q] = 1'b1;
        cnt_d       = SETTLE_LD;
        state_d     = S_DC_SETTLE;
      end

      S_DC_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          vreg_d  = vppg;
          state_d = S_DC_EVAL;
        end
      end

      S_DC_EVAL: begin
        if (vreg_q < TARGET_V) begin
          dc_d[bit_q] = 1'b0;
        end
        if (bit_q == 3'd0) begin
          bit_d   = 3'd3;
          state_d = S_G_TRY;
        end else begin
          bit_d   = bit_q - 3'd1;
          state_d = S_DC_TRY;
        end
      end

      S_G_TRY: begin
        gain_d[bit_q[1:0]] = 1'b1;
        min_d   = '1;
        max_d   = '0;
        cnt_d   = TOTAL_LD;
        state_d = S_G_MEAS;
      end

      // Counter runs TOTAL..1; the last MEAS_CYCLES counts are the window.
      S_G_MEAS: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= MEAS_LD) begin
          if (vppg < min_q) min_d = vppg;
          if (vppg > max_q) max_d = vppg;
        end
        if (cnt_q == CNT_ONE) begin
          state_d = S_G_EVAL;
        end
      end

      S_G_EVAL: begin
        if (clip) begin
          gain_d[bit_q[1:0]] = 1'b0;
        end
        if (bit_q == 3'd0) begin
          state_d = S_NEXT_LED;
        end else begin
          bit_d   = bit_q - 3'd1;
          state_d = S_G_TRY;
        end
      end

      S_NEXT_LED: begin
        if (!led_sel_q) begin
          dc_red_d   = dc_q;
          gain_red_d = gain_q;
          led_sel_d  = 1'b1;
          led_red_d  = 1'b0;
          led_ir_d   = 1'b1;
          dc_d       = '0;
          gain_d     = '0;
          bit_d      = 3'd6;
          state_d    = S_DC_TRY;
        end else begin
          dc_ir_d    = dc_q;
          gain_ir_d  = gain_q;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          led_sel_d  = 1'b0;
          led_red_d  = 1'b0;
          led_ir_d   = 1'b0;
          state_d    = S_RUN_GAP;
        end
      end

      S_RUN_GAP: begin
        dc_d      = led_sel_q ? dc_ir_q : dc_red_q;
        gain_d    = led_sel_q ? gain_ir_q : gain_red_q;
        led_red_d = !led_sel_q;
        led_ir_d  = led_sel_q;
        cnt_d     = SETTLE_LD;
        state_d   = S_RUN_SETTLE;
      end

      S_RUN_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_RUN_SAMPLE;
        end
      end

      // Strobe, sample and tag are registered together so they appear
      // aligned in the following gap cycle.
      S_RUN_SAMPLE: begin
        svalid_d  = 1'b1;
        sample_d  = vppg;
        sis_ir_d  = led_sel_q;
        led_sel_d = !led_sel_q;
        led_red_d = 1'b0;
        led_ir_d  = 1'b0;
        state_d   = S_RUN_GAP;
      end

      default: state_d = S_IDLE;
    endcase

    // Start is honoured only when not calibrating (IDLE or the run loop).
    if (start && !busy_q) begin
      busy_d    = 1'b1;
      done_d    = 1'b0;
      led_sel_d = 1'b0;
      led_red_d = 1'b1;
      led_ir_d  = 1'b0;
      dc_d      = '0;
      gain_d    = '0;
      bit_d     = 3'd6;
      svalid_d  = 1'b0;
      state_d   = S_DC_TRY;
    end
  end

  assign led_red      = led_red_q;
  assign led_ir       = led_ir_q;
  assign dc_comp      = dc_q;
  assign pga_gain     = gain_q;
  assign busy         = busy_q;
  assign cal_done     = done_q;
  assign dc_red       = dc_red_q;
  assign dc_ir        = dc_ir_q;
  assign gain_red     = gain_red_q;
  assign gain_ir      = gain_ir_q;
  assign sample_valid = svalid_q;
  assign sample       = sample_q;
  assign sample_is_ir = sis_ir_q;

endmodule

// File: tb/tb_ppg_search_ctrl.sv
// tb_ppg_search_ctrl
//   Self-checking bench for ppg_search_ctrl. A channel stub turns the DUT's
//   LED / DC code / gain outputs into vppg (linear DC level plus a sampled
//   sine ripple whose amplitude grows with gain). Expected calibration
//   results come from a scan over all codes of that stub.
module tb_ppg_search_ctrl;

  localparam int SETTLE = 8;
  localparam int MEAS   = 64;
  localparam int BUSY_CYCLES = 2 * (7 * (SETTLE + 2) + 4 * (SETTLE + MEAS + 2) + 1);
  localparam int NVEC = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] vppg;
  logic       led_red, led_ir;
  logic [6:0] dc_comp;
  logic [3:0] pga_gain;
  logic       busy, cal_done;
  logic [6:0] dc_red, dc_ir;
  logic [3:0] gain_red, gain_ir;
  logic       sample_valid;
  logic [7:0] sample;
  logic       sample_is_ir;

  ppg_search_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .MEAS_CYCLES  (MEAS),
    .TARGET       (128),
    .SWING_MAX    (192)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .vppg        (vppg),
    .led_red     (led_red),
    .led_ir      (led_ir),
    .dc_comp     (dc_comp),
    .pga_gain    (pga_gain),
    .busy        (busy),
    .cal_done    (cal_done),
    .dc_red      (dc_red),
    .dc_ir       (dc_ir),
    .gain_red    (gain_red),
    .gain_ir     (gain_ir),
    .sample_valid(sample_valid),
    .sample      (sample),
    .sample_is_ir(sample_is_ir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int off_red;
    int off_ir;
    int slope;
    int amr;
    int aar;
    int ami;
    int aai;
    bit force_sat;
    int e_dcr;
    int e_dci;
    int e_gr;
    int e_gi;
  } vec_t;

  vec_t tab[NVEC];
  vec_t cur;

  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;
  int held_dcr, held_dci, held_gr, held_gi;

  logic [3:0] phase = 4'd0;
  int sine_tab[16] = '{0, 383, 707, 924, 1000, 924, 707, 383,
                       0, -383, -707, -924, -1000, -924, -707, -383};

  logic [46:0] all_outs;
  assign all_outs = {led_red, led_ir, dc_comp, pga_gain, busy, cal_done, dc_red, dc_ir,
                     gain_red, gain_ir, sample_valid, sample, sample_is_ir};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- channel stub ----------------
  always @(posedge clk) phase <= phase + 4'd1;

  // Gain 0 only occurs during DC search, so no ripple there.
  always_comb begin
    int lvl;
    int a;
    int v;
    lvl = (led_ir ? cur.off_ir : cur.off_red) - cur.slope * int'(dc_comp);
    if (lvl < 0) lvl = 0;
    if (lvl > 255) lvl = 255;
    a = 0;
    if (pga_gain != 4'd0)
      a = led_ir ? cur.ami * int'(pga_gain) + cur.aai : cur.amr * int'(pga_gain) + cur.aar;
    v = lvl + (a * sine_tab[phase]) / 1000;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    if (cur.force_sat && pga_gain != 4'd0) v = 255;
    vppg = 8'(v);
  end

  // ---------------- reference model ----------------
  function automatic int m_lvl(input vec_t t, input bit ir, input int dc);
    int l;
    l = (ir ? t.off_ir : t.off_red) - t.slope * dc;
    if (l < 0) l = 0;
    if (l > 255) l = 255;
    return l;
  endfunction

  // Largest code with level >= TARGET, 0 if none.
  function automatic int m_dc(input vec_t t, input bit ir);
    for (int dc = 127; dc >= 0; dc--)
      if (m_lvl(t, ir, dc) >= 128) return dc;
    return 0;
  endfunction

  // Largest gain whose full ripple neither clips nor exceeds the swing limit.
  function automatic int m_gain(input vec_t t, input bit ir, input int dc);
    int lvl, a, hi, lo;
    lvl = m_lvl(t, ir, dc);
    for (int g = 15; g >= 1; g--) begin
      a  = ir ? t.ami * g + t.aai : t.amr * g + t.aar;
      hi = (lvl + a > 255) ? 255 : lvl + a;
      lo = (lvl - a < 0) ? 0 : lvl - a;
      if (!t.force_sat && !(hi == 255 || lo == 0 || hi - lo > 192)) return g;
    end
    return 0;
  endfunction

  always @(negedge clk)
    if (mon_en) check("led_exclusive", 64'(led_red & led_ir), 64'd0);

  // ---------------- run-loop check ----------------
  task automatic run_check(input vec_t t);
    int wait_cnt, since, k;
    logic [7:0] prev_v;
    k = 0; since = 0; wait_cnt = 0; prev_v = vppg;
    while (k < 6 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
      since++;
      if (led_red) check("run_red_codes", {dc_comp, pga_gain}, {7'(t.e_dcr), 4'(t.e_gr)});
      if (led_ir)  check("run_ir_codes", {dc_comp, pga_gain}, {7'(t.e_dci), 4'(t.e_gi)});
      if (sample_valid) begin
        check("gap_leds_off", {led_red, led_ir}, 2'b00);
        check("sample_tag", sample_is_ir, 64'(k % 2));
        check("sample_value", sample, prev_v);
        if (k > 0) check("sample_period", since, 10);
        since = 0;
        k++;
      end
      prev_v = vppg;
    end
    if (k < 6) check("run_timeout", k, 6);
  endtask

  // ---------------- one calibration (entered on a negedge) ----------------
  task automatic run_cal(input vec_t t, input bit noise);
    int cnt;
    cur = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", {busy, cal_done}, 2'b10);
    check("start_leds", {led_red, led_ir}, 2'b10);
    check("results_held", {dc_red, dc_ir, gain_red, gain_ir},
          {7'(held_dcr), 7'(held_dci), 4'(held_gr), 4'(held_gi)});
    cnt = 0;
    while (busy && cnt < 2000) begin
      cnt++;
      start = noise && (cnt == 100 || cnt == 367 || cnt == 600);
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", cnt, BUSY_CYCLES);
    check("cal_done", cal_done, 1);
    check("dc_red", dc_red, t.e_dcr);
    check("dc_ir", dc_ir, t.e_dci);
    check("gain_red", gain_red, t.e_gr);
    check("gain_ir", gain_ir, t.e_gi);
    held_dcr = t.e_dcr; held_dci = t.e_dci; held_gr = t.e_gr; held_gi = t.e_gi;
    run_check(t);
  endtask

  initial begin
    // Hand-derived rows: linear stub, sine stub, forced rail, all-zero.
    tab[0] = '{255, 245, 2, 0, 0, 0, 0, 1'b0, 63, 58, 15, 15};
    tab[1] = '{255, 245, 2, 16, 1, 32, 0, 1'b0, 63, 58, 5, 3};
    tab[2] = '{255, 245, 2, 0, 0, 0, 0, 1'b1, 63, 58, 0, 0};
    tab[3] = '{0, 0, 2, 0, 0, 0, 0, 1'b0, 0, 0, 0, 0};
    for (int i = 4; i < NVEC; i++) begin
      tab[i].off_red   = int'($urandom_range(90, 255));
      tab[i].off_ir    = int'($urandom_range(90, 255));
      tab[i].slope     = int'($urandom_range(1, 3));
      tab[i].amr       = int'($urandom_range(0, 40));
      tab[i].aar       = int'($urandom_range(0, 8));
      tab[i].ami       = int'($urandom_range(0, 40));
      tab[i].aai       = int'($urandom_range(0, 8));
      tab[i].force_sat = ($urandom_range(0, 5) == 0);
      tab[i].e_dcr     = m_dc(tab[i], 1'b0);
      tab[i].e_dci     = m_dc(tab[i], 1'b1);
      tab[i].e_gr      = m_gain(tab[i], 1'b0, tab[i].e_dcr);
      tab[i].e_gi      = m_gain(tab[i], 1'b1, tab[i].e_dci);
    end

    cur = tab[0];
    held_dcr = 0; held_dci = 0; held_gr = 0; held_gi = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("reset_outputs", all_outs, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("reset_beats_start", all_outs, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, led_red, led_ir}, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_search", all_outs, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("stays_idle", {busy, led_red, led_ir, dc_comp}, 0);

    for (int i = 0; i < NVEC; i++) run_cal(tab[i], i == 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppg_search_ctrl.md
Name: ppg_search_ctrl

Overview:
- Digital front-end controller that closes the loop around the finger-clip PPG channel.
- Time-multiplexes the RED and IR LEDs and drives the 7-bit DC compensation DAC code and the 4-bit PGA gain code.
- Calibrates each LED by successive-approximation (binary) search on the returned 8-bit Vppg sample, then runs continuously, emitting tagged per-LED samples to the downstream SpO2 logic.

Parameters:
- SETTLE_CYCLES, 8: clock cycles to wait after any change of LED/dc_comp/pga_gain before Vppg is used (must be >= 1).
- MEAS_CYCLES, 64: min/max tracking window per gain trial; must cover at least one full pulse period.
- TARGET, 128: DC-search threshold on Vppg (8-bit).
- SWING_MAX, 192: maximum allowed peak-to-peak Vppg during gain search.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins or restarts calibration
- vppg  in  8  digitised PPG sample from the finger-clip channel
- led_red  out  1  RED LED enable
- led_ir  out  1  IR LED enable
- dc_comp  out  7  DC compensation code
- pga_gain  out  4  PGA gain code
- busy  out  1  high while calibrating
- cal_done  out  1  level; high from calibration end until the next start or reset
- dc_red, dc_ir  out  7 each  calibrated DC codes
- gain_red, gain_ir  out  4 each  calibrated gain codes
- sample_valid  out  1  one-cycle strobe in RUN
- sample  out  8  Vppg captured with the strobe
- sample_is_ir  out  1  0 = RED sample, 1 = IR sample

Behaviour:
- Reset (synchronous, active-high; wins over everything, including mid-search or mid-RUN): state IDLE; every output is 0, including both LEDs, busy, cal_done, sample_valid and all stored codes.
- Invariant: led_red and led_ir are never high in the same cycle.
- States: IDLE, DC_TRY, DC_SETTLE, DC_EVAL, G_TRY, G_MEAS, G_EVAL, NEXT_LED, RUN_GAP, RUN_SETTLE, RUN_SAMPLE.
- IDLE, start=1: busy<=1, cal_done<=0, led=RED, dc_comp<=0, pga_gain<=0, bit index b<=6, then DC_TRY.
- DC phase (pga_gain held at 0):
  - DC_TRY (1 cycle): set dc_comp[b]; load settle counter with SETTLE_CYCLES.
  - DC_SETTLE: counts SETTLE_CYCLES cycles; vppg is registered on the last one.
  - DC_EVAL (1 cycle): if registered vppg < TARGET, clear dc_comp[b]. If b==0 go to G_TRY with b<=3; else b<=b-1 and go to DC_TRY.
  - Cost: 7*(SETTLE_CYCLES+2) cycles per LED.
  - Result: the largest code for which vppg >= TARGET; 0 if none.
- Gain phase:
  - G_TRY (1 cycle): set pga_gain[b]; min<=255, max<=0; counter<=SETTLE_CYCLES+MEAS_CYCLES.
  - G_MEAS: the first SETTLE_CYCLES cycles are ignored; the following MEAS_CYCLES cycles update min/max from vppg.
  - G_EVAL (1 cycle): clip = (max==255) | (min==0) | ((max-min) > SWING_MAX), with the difference computed at 9 bits unsigned. If clip, clear pga_gain[b]. If b==0 go to NEXT_LED; else b<=b-1 and go to G_TRY.
- NEXT_LED (1 cycle):
  - Store dc_comp/pga_gain into the current LED's result registers.
  - If current LED is RED: switch to IR, dc_comp<=0, pga_gain<=0, b<=6, go to DC_TRY.
  - If current LED is IR: busy<=0, cal_done<=1, go to RUN_GAP with next LED = RED.
- RUN loop:
  - RUN_GAP (1 cycle): both LEDs off; load dc_comp/pga_gain from the next LED's stored codes.
  - RUN_SETTLE: that LED on for SETTLE_CYCLES cycles.
  - RUN_SAMPLE (1 cycle): LED still on; sample<=vppg, sample_is_ir<=LED, sample_valid=1; toggle the LED; go to RUN_GAP.
  - Sample period is SETTLE_CYCLES+2 cycles, strictly alternating RED, IR, RED, ...
- Boundary behaviour:
  - start is ignored while busy.
  - start in RUN restarts calibration from RED with cal_done<=0; result registers keep their old values until overwritten by NEXT_LED.
  - start in the same cycle as reset: reset wins.
  - vppg is treated as unsigned; no saturation is needed on the stored codes.

Test Plan:
- Reset mid-DC-search (cycle 20 after start) -> next cycle all outputs 0 and state IDLE; a new start runs a full calibration.
- Bench stub vppg = 255-2*dc_comp (RED) / 245-2*dc_comp (IR), gain 0, no ripple; pulse start -> dc_red=63, dc_ir=58. busy stays high for exactly 2*(7*10+4*(72+2)+1) cycles with default parameters (SETTLE_CYCLES=8, MEAS_CYCLES=64), then cal_done=1.
- Same stub plus a sine of amplitude 16*g+1 (RED) / 32*g (IR) around the DC value -> gain_red=5, gain_ir=3.
- Stub forcing vppg=255 in every gain trial -> all four gain bits cleared, gain=0; vppg=0 throughout -> dc=0 and gain=0.
- RUN check after calibration: sample_valid pulses every 10 cycles with sample_is_ir alternating 0,1,0,1. dc_comp/pga_gain equal the stored codes of the lit LED, and both LEDs are off on every gap cycle. A checker flags any cycle with both LEDs high.
- start pulses during calibration are ignored, with busy and results unaffected; a start during RUN gives busy=1 and cal_done=0 on the next cycle, and calibration restarts with led_red=1.
